// File: rtl/pwm_sequencer_pkg.sv
// Shared types and helpers for the PWM colour sequencer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: FSM state enum, mode encodings, saturating duty step helper.
package pwm_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } seq_state_e;

  localparam logic MODE_SEQ    = 1'b0;  // one channel ramps at a time
  localparam logic MODE_UNISON = 1'b1;  // all channels ramp together

  // Widest duty the helper handles; callers zero-extend into this word and
  // truncate the result back to their own width.
  localparam int DUTY_W_MAX = 16;
  typedef logic [DUTY_W_MAX-1:0] duty_word_t;

  // Saturating step towards max_val (up=1) or towards 0 (up=0). The
  // headroom compare avoids needing a carry/borrow bit.
  function automatic duty_word_t duty_step(input duty_word_t val,
                                           input duty_word_t inc,
                                           input duty_word_t max_val,
                                           input logic       up);
    duty_word_t res;
    if (up) begin
      res = ((max_val - val) <= inc) ? max_val : (val + inc);
    end else begin
      res = (val <= inc) ? '0 : (val - inc);
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Ramp tick divider: one-cycle tick strobe every DIV enabled clocks.
// Latency: tick is combinational from the counter; first tick DIV enabled clks after reset/clear.
// Backpressure: none; en=0 freezes the count, clr forces it back to 0.
//
// Ports: clk, rst (async active-low), en (count enable), clr (sync clear,
// used when the sequencer restarts), tick (strobe while counter = DIV-1).
module pwm_tick_gen #(
  parameter int DIV = 625000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_sequencer.sv
// RGB-style PWM sequencer: triangle-ramps channel duties, sequentially or in unison.
// Latency: duty/active_ch update the clk after a tick; pwm_out follows duty one clk later.
// Backpressure: none; en=0 freezes sequencing while the PWM waveform keeps running.
//
// Ports: clk, rst (async active-low), en, mode (0 sequential / 1 unison),
// step (duty increment, 0 acts as 1), duty (CH*W packed, ch i at [i*W +: W]),
// pwm_out (per channel), active_ch (ramping channel), seq_done (1-clk pulse).
module pwm_sequencer
  import pwm_sequencer_pkg::*;
#(
  parameter  int CH  = 3,
  parameter  int W   = 8,       // at most DUTY_W_MAX
  parameter  int DIV = 625000,
  localparam int AW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [W-1:0]    step,
  output logic [CH*W-1:0] duty,
  output logic [CH-1:0]   pwm_out,
  output logic [AW-1:0]   active_ch,
  output logic            seq_done
);

  localparam logic [W-1:0]  MAX     = '1;
  localparam logic [AW-1:0] LAST_CH = AW'(CH - 1);

  seq_state_e    state_q, state_d;
  logic [W-1:0]  ramp_q, ramp_d;
  logic [W-1:0]  duty_q [CH];
  logic [W-1:0]  duty_d [CH];
  logic [AW-1:0] act_q, act_d;
  logic          mode_q, mode_d;
  logic          done_q, done_d;
  logic [W-1:0]  pcnt_q, pcnt_d;
  logic [CH-1:0] pwm_q, pwm_d;

  logic          tick;
  logic          restart;
  logic [W-1:0]  step_eff;
  logic [W-1:0]  ramp_up, ramp_dn;

  // Any change of mode against the registered copy restarts the sequence.
  assign restart  = (mode != mode_q);
  assign step_eff = (step == '0) ? W'(1) : step;

  assign ramp_up = W'(duty_step(duty_word_t'(ramp_q), duty_word_t'(step_eff),
                                duty_word_t'(MAX), 1'b1));
  assign ramp_dn = W'(duty_step(duty_word_t'(ramp_q), duty_word_t'(step_eff),
                                duty_word_t'(MAX), 1'b0));

  pwm_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (restart),
    .tick (tick)
  );

  // Sequencing FSM: all movement happens on tick; restart overrides it.
  always_comb begin
    state_d = state_q;
    ramp_d  = ramp_q;
    act_d   = act_q;
    done_d  = 1'b0;
    mode_d  = mode;
    if (restart) begin
      state_d = ST_UP;
      ramp_d  = '0;
      act_d   = '0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: state_d = ST_UP;
        ST_UP: begin
          ramp_d = ramp_up;
          if (ramp_up == MAX) state_d = ST_DOWN;
        end
        ST_DOWN: begin
          ramp_d = ramp_dn;
          if (ramp_dn == '0) begin
            state_d = ST_UP;
            if (mode_q == MODE_UNISON) begin
              done_d = 1'b1;
            end else if (act_q == LAST_CH) begin
              act_d  = '0;
              done_d = 1'b1;
            end else begin
              act_d = act_q + AW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Duty fan-out and PWM compare. The duties are derived from the next ramp
  // value so they land on the same edge as the FSM update.
  always_comb begin
    pcnt_d = pcnt_q + W'(1);
    for (int i = 0; i < CH; i++) begin
      if (mode_q == MODE_UNISON || act_d == AW'(i)) duty_d[i] = ramp_d;
      else                                          duty_d[i] = '0;
      pwm_d[i] = (pcnt_q < duty_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ramp_q  <= '0;
      duty_q  <= '{default: '0};
      act_q   <= '0;
      mode_q  <= MODE_SEQ;
      done_q  <= 1'b0;
      pcnt_q  <= '0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      ramp_q  <= ramp_d;
      duty_q  <= duty_d;
      act_q   <= act_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      pcnt_q  <= pcnt_d;
      pwm_q   <= pwm_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_duty
    assign duty[g*W +: W] = duty_q[g];
  end

  assign pwm_out   = pwm_q;
  assign active_ch = act_q;
  assign seq_done  = done_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer with CH=3, W=4, DIV=4.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_pwm_sequencer;

  localparam int CH  = 3;
  localparam int W   = 4;
  localparam int DIV = 4;
  localparam int AW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            mode;
  logic [W-1:0]    step;
  logic [CH*W-1:0] duty;
  logic [CH-1:0]   pwm_out;
  logic [AW-1:0]   active_ch;
  logic            seq_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pwm_sequencer #(.CH(CH), .W(W), .DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .step      (step),
    .duty      (duty),
    .pwm_out   (pwm_out),
    .active_ch (active_ch),
    .seq_done  (seq_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step-1 triangle: position p within a 30-tick ramp (0..15..0).
  function automatic int tri_v(input int p);
    return (p <= 15) ? p : 30 - p;
  endfunction

  task automatic do_reset(input logic [W-1:0] s);
    rst  = 1'b0;
    en   = 1'b0;
    mode = 1'b0;
    step = s;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
  endtask

  // Advance one tick period; seq_done must be low away from tick edges.
  task automatic tick_wait();
    repeat (DIV - 1) @(negedge clk);
    check("seq_done_between_ticks", 32'(seq_done), 0);
    @(negedge clk);
  endtask

  initial begin
    int exp_v, t, c, hi, lo;
    int exp6 [7];
    int exp0 [7];
    int stp0 [7];
    exp6 = '{0, 6, 12, 15, 9, 3, 0};
    exp0 = '{0, 1, 2, 3, 8, 15, 13};
    stp0 = '{0, 0, 0, 0, 5, 15, 2};

    // Reset state, sampled while reset is held.
    rst = 1'b0; en = 1'b0; mode = 1'b0; step = 4'd1;
    #12;
    check("rst_duty", 32'(duty), 0);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_active", 32'(active_ch), 0);
    check("rst_done", 32'(seq_done), 0);

    // Full sequential run, step 1: 91 ticks to seq_done.
    do_reset(4'd1);
    repeat (3) @(negedge clk);
    check("pre_tick_duty", 32'(duty), 0);
    @(negedge clk);
    check("first_tick_duty", 32'(duty), 0);
    for (int k = 2; k <= 91; k++) begin
      tick_wait();
      t = k - 1;
      c = (t / 30) % 3;
      exp_v = tri_v(t % 30) << (c * W);
      check("seq_duty", 32'(duty), exp_v);
      check("seq_active", 32'(active_ch), c);
      check("seq_done", 32'(seq_done), (k == 91) ? 1 : 0);
    end

    // Freeze at duty 5 for 100 clks; PWM keeps running at 5/16.
    do_reset(4'd1);
    repeat (6) tick_wait();
    check("hold_pre_duty", 32'(duty), 5);
    en = 1'b0;
    hi = 0; lo = 0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      hi += int'(pwm_out[0]);
      lo += int'(pwm_out[1]) + int'(pwm_out[2]);
    end
    repeat (4) @(negedge clk);
    check("hold_pwm_high", hi, 30);
    check("hold_pwm_others", lo, 0);
    check("hold_duty", 32'(duty), 5);
    check("hold_active", 32'(active_ch), 0);
    en = 1'b1;
    repeat (DIV) @(negedge clk);
    check("resume_duty", 32'(duty), 6);

    // Step 6: saturation at both ends, PWM at MAX is high 15 of 16.
    do_reset(4'd6);
    for (int k = 1; k <= 7; k++) begin
      tick_wait();
      check("step6_duty", 32'(duty), exp6[k-1]);
      if (k == 4) begin
        en = 1'b0;
        hi = 0;
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          hi += int'(pwm_out[0]);
        end
        check("max_pwm_high", hi, 15);
        en = 1'b1;
      end
    end
    check("step6_active", 32'(active_ch), 1);

    // step 0 acts as 1; step changes apply at the next tick.
    do_reset(4'd0);
    for (int k = 1; k <= 7; k++) begin
      step = 4'(stp0[k-1]);
      tick_wait();
      check("step0_duty", 32'(duty), exp0[k-1]);
    end

    // Mode switch mid-ramp, then unison ramps with seq_done every 30 ticks.
    do_reset(4'd1);
    repeat (10) tick_wait();
    check("pre_switch_duty", 32'(duty), 9);
    mode = 1'b1;
    @(negedge clk);
    check("switch_duty", 32'(duty), 0);
    check("switch_active", 32'(active_ch), 0);
    check("switch_done", 32'(seq_done), 0);
    for (int n = 1; n <= 60; n++) begin
      tick_wait();
      t = tri_v(n % 30);
      exp_v = t | (t << 4) | (t << 8);
      check("unison_duty", 32'(duty), exp_v);
      check("unison_active", 32'(active_ch), 0);
      check("unison_done", 32'(seq_done), (n % 30 == 0) ? 1 : 0);
    end

    // Asynchronous reset while duty[1] = 9.
    do_reset(4'd1);
    repeat (40) tick_wait();
    check("pre_rst_duty", 32'(duty), 9 << 4);
    check("pre_rst_active", 32'(active_ch), 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_duty", 32'(duty), 0);
    check("async_rst_active", 32'(active_ch), 0);
    check("async_rst_pwm", 32'(pwm_out), 0);
    check("async_rst_done", 32'(seq_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (7) @(negedge clk);
    check("restart_clk7_duty", 32'(duty), 0);
    @(negedge clk);
    check("restart_clk8_duty", 32'(duty), 1);
    check("restart_active", 32'(active_ch), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 Parameter CH, default 3, number of colour channels (>=1).
REQ-002 Parameter W, default 8, duty width in bits; MAX = 2^W-1.
REQ-003 Parameter DIV, default 625000, clk cycles per ramp tick (>=2).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  1 = sequencing runs; 0 = freeze.
REQ-007 mode  input  1  0 = sequential (one channel at a time), 1 = unison (all channels ramp together).
REQ-008 step  input  W  duty increment per tick; 0 treated as 1.
REQ-009 duty  output  CH*W  per-channel duty, channel i at bits [i*W +: W].
REQ-010 pwm_out  output  CH  registered PWM waveform per channel.
REQ-011 active_ch  output  max(1,clog2(CH))  channel currently ramping.
REQ-012 seq_done  output  1  one-clk pulse at end of a full sequence.

Function
REQ-013 Tick counter 0..DIV-1, advancing only while en=1; tick = 1-cycle strobe when counter = DIV-1 (counter then wraps to 0); no derived clocks.
REQ-014 en=0 holds tick counter, FSM state, duty, active_ch; pwm_out keeps running from held duty.
REQ-015 FSM states IDLE, UP, DOWN; all transitions occur only on tick.
REQ-016 IDLE -> UP on first tick, duty unchanged (all 0), active_ch = 0.
REQ-017 UP: ramp value += step, saturating at MAX; when result = MAX -> DOWN.
REQ-018 DOWN: ramp value -= step, saturating at 0; when result = 0 -> UP and ramp ends.
REQ-019 Mode 0: ramp value drives duty[active_ch] only, all other duties forced 0; at ramp end active_ch increments, wrapping CH-1 -> 0.
REQ-020 Mode 0: seq_done pulses on the tick where active_ch wraps CH-1 -> 0.
REQ-021 Mode 1: all duty channels equal the ramp value; active_ch held 0; seq_done pulses on each ramp end.
REQ-022 mode registered; a change from the registered value restarts on the next clk: duties 0, active_ch 0, state UP, tick counter 0, no seq_done.
REQ-023 step sampled at each tick; mid-ramp changes take effect on the next tick.
REQ-024 PWM counter: free-running W-bit, increments every clk regardless of en, wraps MAX -> 0 (period 2^W).
REQ-025 pwm_out[i] registered = (pwm counter < duty[i]); duty 0 -> constant 0; duty MAX -> low 1 of 2^W cycles.
REQ-026 Output latency: duty and active_ch update on the clk edge after the tick; pwm_out follows duty one clk later.

Reset
REQ-027 rst low asynchronously clears: tick counter 0, PWM counter 0, state IDLE, duty all 0, active_ch 0, pwm_out 0, seq_done 0, registered mode 0.
REQ-028 rst asserted mid-ramp discards all progress; after release the sequence restarts from IDLE.
REQ-029 Reset release requires no other input; first tick occurs DIV enabled clks after release.

Structure
REQ-030 Shared package holds FSM state enum (IDLE/UP/DOWN), mode encodings, and a duty saturating add/sub helper.
REQ-031 Tick divider is a sub-module, pwm_tick_gen (params DIV; ports clk, rst, en, tick).
REQ-032 Ramp value is one W-bit register plus per-channel duty registers; no arithmetic wider than W+1 bits.

Verification (bench CH=3, W=4, DIV=4)
REQ-033 mode0, step=1, en=1 after reset -> duty[0] 0,1..15,14..0, then duty[1] ramps; seq_done single pulse after 91 ticks (364 clks); others 0 throughout.
REQ-034 mode0, step=6 -> duty[0] 0,6,12,15,9,3,0 then active_ch=1 (saturation both ends).
REQ-035 Hold en=0 with duty[0]=5 for 100 clks -> duty frozen at 5; pwm_out[0] high exactly 5 of every 16 clks.
REQ-036 mode 0->1 mid-ramp -> next clk all duties 0, active_ch 0; then all three duties ramp identically; seq_done pulses every 30 ticks.
REQ-037 rst low while duty[1]=9 -> all outputs 0 immediately, asynchronously; after release IDLE, first tick at clk 4, duty[0] restarts from 0.
REQ-038 step=0 -> behaves exactly as step=1 (duty[0] 0,1,2,...).
